// File: rtl/tlb_walker.sv
// Sv39/Sv48 page-table walker for the TLB miss path: one outstanding PTE read at a time.
// A leaf PTE produces a one-cycle TLB write strobe. A bad walk produces a page-fault or access-fault pulse.
module tlb_walker #(
    parameter int XLEN     = 64,
    parameter int PA_BITS  = 56,
    parameter int PPN_BITS = 44
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [3:0]          SATP_MODE,
    input  logic [PPN_BITS-1:0] SATP_PPN,
    input  logic [XLEN-1:0]     VAdr,
    input  logic                TLBMiss,
    input  logic                TLBFlush,
    output logic                MemReqValid,
    input  logic                MemReqReady,
    output logic [PA_BITS-1:0]  MemReqAdr,
    input  logic                MemRspValid,
    input  logic [XLEN-1:0]     MemRspData,
    input  logic                MemRspErr,
    output logic [XLEN-1:0]     PTE,
    output logic [1:0]          PageTypeWriteVal,
    output logic                TLBWrite,
    output logic                WalkerPageFault,
    output logic                WalkerAccessFault,
    output logic                Busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_LEAF,
        S_PFAULT,
        S_AFAULT,
        S_DRAIN
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            level_q, level_d;
    logic [PPN_BITS-1:0]   base_q, base_d;
    logic [35:0]           vpn_q, vpn_d;
    logic [XLEN-1:0]       pte_q, pte_d;
    logic [1:0]            ptype_q, ptype_d;

    logic                  mode_ok;
    logic                  req_fire;
    logic [8:0]            vpn_sel;
    logic [PPN_BITS+11:0]  req_adr_full;
    logic                  pte_bad;
    logic                  pte_leaf;
    logic                  nonleaf_rsvd;

    assign mode_ok  = (SATP_MODE == 4'd8) || (SATP_MODE == 4'd9);
    assign req_fire = (state_q == S_REQ) && MemReqReady;

    // PTE classification. Checks are applied in priority order in S_WAIT.
    assign pte_bad      = !MemRspData[0] || (!MemRspData[1] && MemRspData[2])
                          || (MemRspData[63:54] != 10'd0);
    assign pte_leaf     = MemRspData[1] || MemRspData[3];
    assign nonleaf_rsvd = (MemRspData[7:4] != 4'd0);

    always_comb begin
        case (level_q)
            2'd0:    vpn_sel = vpn_q[8:0];
            2'd1:    vpn_sel = vpn_q[17:9];
            2'd2:    vpn_sel = vpn_q[26:18];
            default: vpn_sel = vpn_q[35:27];
        endcase
    end

    assign req_adr_full = {base_q, vpn_sel, 3'b000};

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
        state_d = state_q;
        level_d = level_q;
        base_d  = base_q;
        vpn_d   = vpn_q;
        pte_d   = pte_q;
        ptype_d = ptype_q;

        case (state_q)
            S_IDLE: begin
                if (TLBMiss && !TLBFlush && mode_ok) begin
                    vpn_d   = VAdr[47:12];
                    level_d = (SATP_MODE == 4'd9) ? 2'd3 : 2'd2;
                    base_d  = SATP_PPN;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (TLBFlush)
                    state_d = req_fire ? S_DRAIN : S_IDLE;
                else if (req_fire)
                    state_d = S_WAIT;
            end
            S_WAIT: begin
                // A flush coinciding with the response drops that response. Otherwise the walker drains it later.
                if (TLBFlush) begin
                    state_d = MemRspValid ? S_IDLE : S_DRAIN;
                end else if (MemRspValid) begin
                    if (MemRspErr) begin
                        state_d = S_AFAULT;
                    end else if (pte_bad) begin
                        state_d = S_PFAULT;
                    end else if (pte_leaf) begin
                        pte_d   = MemRspData;
                        ptype_d = level_q;
                        state_d = S_LEAF;
                    end else if (nonleaf_rsvd || (level_q == 2'd0)) begin
                        state_d = S_PFAULT;
                    end else begin
                        base_d  = MemRspData[PPN_BITS+9:10];
                        level_d = level_q - 2'd1;
                        state_d = S_REQ;
                    end
                end
            end
            S_LEAF, S_PFAULT, S_AFAULT: state_d = S_IDLE;
            S_DRAIN: begin
                if (MemRspValid)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state flops use non-blocking assignments, so each flop sees the pre-edge values of the others.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            level_q <= 2'd0;
            base_q  <= '0;
            vpn_q   <= '0;
            pte_q   <= '0;
            ptype_q <= 2'd0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            base_q  <= base_d;
            vpn_q   <= vpn_d;
            pte_q   <= pte_d;
            ptype_q <= ptype_d;
        end
    end

    assign MemReqValid       = (state_q == S_REQ);
    assign MemReqAdr         = (state_q == S_REQ) ? req_adr_full[PA_BITS-1:0] : '0;
    assign PTE               = pte_q;
    assign PageTypeWriteVal  = ptype_q;
    assign TLBWrite          = (state_q == S_LEAF);
    assign WalkerPageFault   = (state_q == S_PFAULT);
    assign WalkerAccessFault = (state_q == S_AFAULT);
    assign Busy              = (state_q != S_IDLE);

endmodule
